// File: rtl/dsp_mac_array.sv
// dsp_mac_array: G_SIZE independent signed multiply-accumulate channels sharing
// one valid/mode/clock-enable pipeline. Each channel forms A*B, optionally adds
// it to its own previous result or to a piped C operand, and registers the
// result together with a signed-overflow flag and a masked pattern-match flag.
module dsp_mac_array #(
    parameter int                 G_SIZE  = 4,
    parameter int                 A_WIDTH = 27,
    parameter int                 B_WIDTH = 18,
    parameter int                 P_WIDTH = 48,
    parameter int                 IN_REG  = 2,
    parameter int                 MREG    = 1,
    parameter logic [P_WIDTH-1:0] PATTERN = '0,
    parameter logic [P_WIDTH-1:0] MASK    = '0
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        CE,
    input  logic                        IN_VALID,
    input  logic [1:0]                  MODE,
    input  logic [G_SIZE*A_WIDTH-1:0]   A,
    input  logic [G_SIZE*B_WIDTH-1:0]   B,
    input  logic [G_SIZE*P_WIDTH-1:0]   C,
    output logic                        OUT_VALID,
    output logic [G_SIZE*P_WIDTH-1:0]   P,
    output logic [G_SIZE-1:0]           OVERFLOW,
    output logic [G_SIZE-1:0]           PATDET
);

    localparam int AW_ALL = G_SIZE * A_WIDTH;
    localparam int BW_ALL = G_SIZE * B_WIDTH;
    localparam int PW_ALL = G_SIZE * P_WIDTH;
    localparam int PROD_W = A_WIDTH + B_WIDTH;

    typedef enum logic [1:0] {
        MODE_MUL      = 2'b00,
        MODE_ACC      = 2'b01,
        MODE_MULADD_C = 2'b10,
        MODE_HOLD     = 2'b11
    } macMode_e;

    // Operands and control as seen by the multiplier (after the input stages)
    logic [AW_ALL-1:0] aStage;
    logic [BW_ALL-1:0] bStage;
    logic [PW_ALL-1:0] cStage;
    logic              validStage;
    macMode_e          modeStage;

    // Sign-extended products straight out of the multipliers
    logic [PW_ALL-1:0] mulProd;

    // Operands and control as seen by the final adder stage
    logic [PW_ALL-1:0] mulFinal;
    logic [PW_ALL-1:0] cFinal;
    logic              validFinal;
    macMode_e          modeFinal;

    // Result registers and the values a valid beat would write into them
    logic [PW_ALL-1:0] pOut_q;
    logic [PW_ALL-1:0] pNext_d;
    logic [G_SIZE-1:0] ovfOut_q;
    logic [G_SIZE-1:0] ovfNext_d;
    logic [G_SIZE-1:0] patOut_q;
    logic [G_SIZE-1:0] patNext_d;
    logic              outValid_q;

    // ------------------------------------------------------------------
    // Input pipeline: A/B/C travel with their own valid and mode so each
    // beat keeps its operation all the way to the adder.
    // ------------------------------------------------------------------
    if (IN_REG == 0) begin : gInComb
        assign aStage     = A;
        assign bStage     = B;
        assign cStage     = C;
        assign validStage = IN_VALID;
        assign modeStage  = macMode_e'(MODE);
    end else begin : gInReg
        logic [AW_ALL-1:0] aPipe_q     [IN_REG];
        logic [BW_ALL-1:0] bPipe_q     [IN_REG];
        logic [PW_ALL-1:0] cPipe_q     [IN_REG];
        macMode_e          modePipe_q  [IN_REG];
        logic [IN_REG-1:0] validPipe_q;

        // Shift operands and control one stage per enabled clock; reset wins over CE
        always_ff @(posedge CLK) begin
            if (RST) begin
                for (int s = 0; s < IN_REG; s++) begin
                    aPipe_q[s]    <= '0;
                    bPipe_q[s]    <= '0;
                    cPipe_q[s]    <= '0;
                    modePipe_q[s] <= MODE_MUL;
                end
                validPipe_q <= '0;
            end else if (CE) begin
                aPipe_q[0]     <= A;
                bPipe_q[0]     <= B;
                cPipe_q[0]     <= C;
                modePipe_q[0]  <= macMode_e'(MODE);
                validPipe_q[0] <= IN_VALID;
                for (int s = 1; s < IN_REG; s++) begin
                    aPipe_q[s]     <= aPipe_q[s-1];
                    bPipe_q[s]     <= bPipe_q[s-1];
                    cPipe_q[s]     <= cPipe_q[s-1];
                    modePipe_q[s]  <= modePipe_q[s-1];
                    validPipe_q[s] <= validPipe_q[s-1];
                end
            end
        end

        assign aStage     = aPipe_q[IN_REG-1];
        assign bStage     = bPipe_q[IN_REG-1];
        assign cStage     = cPipe_q[IN_REG-1];
        assign modeStage  = modePipe_q[IN_REG-1];
        assign validStage = validPipe_q[IN_REG-1];
    end

    // ------------------------------------------------------------------
    // Per-channel signed x signed multiplier, sign-extended to P_WIDTH.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < G_SIZE; k++) begin : gMul
        logic signed [A_WIDTH-1:0] aK;
        logic signed [B_WIDTH-1:0] bK;
        logic signed [PROD_W-1:0]  prodK;

        assign aK    = aStage[k*A_WIDTH +: A_WIDTH];
        assign bK    = bStage[k*B_WIDTH +: B_WIDTH];
        assign prodK = PROD_W'(aK) * PROD_W'(bK);
        assign mulProd[k*P_WIDTH +: P_WIDTH] = P_WIDTH'(prodK);
    end

    // ------------------------------------------------------------------
    // Optional multiplier output register; C, valid and mode ride along.
    // ------------------------------------------------------------------
    if (MREG == 0) begin : gMulComb
        assign mulFinal   = mulProd;
        assign cFinal     = cStage;
        assign validFinal = validStage;
        assign modeFinal  = modeStage;
    end else begin : gMulReg
        logic [PW_ALL-1:0] mulReg_q;
        logic [PW_ALL-1:0] cReg_q;
        logic              validReg_q;
        macMode_e          modeReg_q;

        // Register products alongside their C operand and control; reset wins over CE
        always_ff @(posedge CLK) begin
            if (RST) begin
                mulReg_q   <= '0;
                cReg_q     <= '0;
                validReg_q <= 1'b0;
                modeReg_q  <= MODE_MUL;
            end else if (CE) begin
                mulReg_q   <= mulProd;
                cReg_q     <= cStage;
                validReg_q <= validStage;
                modeReg_q  <= modeStage;
            end
        end

        assign mulFinal   = mulReg_q;
        assign cFinal     = cReg_q;
        assign validFinal = validReg_q;
        assign modeFinal  = modeReg_q;
    end

    // ------------------------------------------------------------------
    // Final adder per channel: choose the addend from the beat's mode,
    // add modulo 2^P_WIDTH, and derive the overflow and pattern flags.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < G_SIZE; k++) begin : gFinal
        logic signed [P_WIDTH-1:0] mK;
        logic signed [P_WIDTH-1:0] cK;
        logic signed [P_WIDTH-1:0] pK;
        logic signed [P_WIDTH-1:0] addendK;
        logic signed [P_WIDTH-1:0] sumK;
        logic        [P_WIDTH-1:0] pNextK;
        logic                      ovfK;

        assign mK      = mulFinal[k*P_WIDTH +: P_WIDTH];
        assign cK      = cFinal[k*P_WIDTH +: P_WIDTH];
        assign pK      = pOut_q[k*P_WIDTH +: P_WIDTH];
        assign addendK = (modeFinal == MODE_ACC) ? pK : cK;
        assign sumK    = addendK + mK;

        // Pick the value this beat writes to P; overflow only exists for the adding modes
        always_comb begin
            pNextK = pK;
            ovfK   = 1'b0;
            case (modeFinal)
                MODE_MUL: begin
                    pNextK = mK;
                end
                MODE_ACC, MODE_MULADD_C: begin
                    pNextK = sumK;
                    ovfK   = (addendK[P_WIDTH-1] == mK[P_WIDTH-1]) &&
                             (sumK[P_WIDTH-1] != addendK[P_WIDTH-1]);
                end
                default: begin
                    pNextK = pK;
                end
            endcase
        end

        assign pNext_d[k*P_WIDTH +: P_WIDTH] = pNextK;
        assign ovfNext_d[k] = ovfK;
        assign patNext_d[k] = (((pNextK ^ PATTERN) & ~MASK) == '0);
    end

    // Result registers: bubbles hold P and flags, only valid beats update them
    always_ff @(posedge CLK) begin
        if (RST) begin
            pOut_q     <= '0;
            ovfOut_q   <= '0;
            patOut_q   <= '0;
            outValid_q <= 1'b0;
        end else if (CE) begin
            outValid_q <= validFinal;
            if (validFinal) begin
                pOut_q   <= pNext_d;
                ovfOut_q <= ovfNext_d;
                patOut_q <= patNext_d;
            end
        end
    end

    assign P         = pOut_q;
    assign OVERFLOW  = ovfOut_q;
    assign PATDET    = patOut_q;
    assign OUT_VALID = outValid_q;

endmodule
